bcd_scan_capture: RTL and testbench
===================================

Name: bcd_scan_capture

Overview:
- Receive-side counterpart of the 8-digit multiplexed display driver: samples the active-low one-hot anode strobe and the shared 4-bit BCD bus, and rebuilds the eight digit values.
- Emits one complete frame per scan cycle, with a per-digit valid mask and error flags.
- Sits on the lab board between a probed or external scan bus and a checker or logger, or closes an on-chip loopback against the driver for self-test.

Parameters:
- STABLE_CYC, 2: consecutive identical synchronised samples (anode and bcd) required before a slot is accepted. Legal range 1..15.
- TIMEOUT_CYC, 1024: cycles with no accepted digit before an open frame is force-closed. Legal range 16..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- anodo_in  in  8  scanned anodes, active-low; bit k low selects position k
- bcd_in  in  4  digit value present during the active anode
- d1..d8  out  4 each  reconstructed digits; anode bit 7 -> d1, bit 6 -> d2, ..., bit 0 -> d8
- digit_valid  out  8  bit k = position k was captured in the last closed frame
- frame_done  out  1  one-cycle pulse when d1..d8 and digit_valid update
- multi_err  out  1  one-cycle pulse on an accepted slot with more than one anode low
- timeout  out  1  one-cycle pulse coincident with a frame_done caused by timeout

Behaviour:
- Reset (reset=0, asynchronous):
  - d1..d8 = 0, digit_valid = 0, all pulses = 0.
  - Sync register = 8'hFF/4'h0, stability counter = 0, shadow registers and shadow mask cleared.
  - last_idx invalid, frame open flag = 0, timeout counter = 0.
  - Reset mid-frame discards the partial frame and produces no frame_done.
- Input stage: anodo_in and bcd_in are registered once. All further logic sees only the registered copy, so there is 1 cycle of input latency.
- Stability filter:
  - The counter resets to 1 whenever the registered {anode,bcd} differs from the previous cycle. Otherwise it increments, saturating at 15.
  - A slot is accepted in the cycle the counter equals STABLE_CYC. This gives exactly one acceptance per stable interval.
  - Minimum latency from a bus change to shadow write is STABLE_CYC+1 cycles.
- Slot decode (on acceptance):
  - anode == 8'hFF: blank slot. Nothing is captured and the timeout counter is not reset.
  - Exactly one bit k low: capture. shadow[k] <= bcd and mask[k] <= 1. BCD codes 10..15 are stored raw, unchecked.
  - Two or more bits low: multi_err pulses the next cycle. There is no capture and no change to frame state.
- Frame close by wrap:
  - Triggered when a capture at index k occurs with frame open and k <= last_idx.
  - Same cycle: d1..d8 <= shadow (for mask=1 positions) and digit_valid <= mask. Positions with mask=0 keep their previous d value.
  - Next cycle: frame_done pulses.
  - The new frame starts with mask = only bit k set and last_idx = k. The current capture is not lost.
- Frame close by timeout:
  - The counter increments every cycle while the frame is open and resets on each capture.
  - At TIMEOUT_CYC-1 the frame closes as above, and frame_done and timeout pulse together.
  - The frame open flag is then cleared and the counter stops.
- First capture after reset or timeout: opens a frame with last_idx = k and produces no frame_done.
- Captures with k > last_idx: stay in the current frame, last_idx <= k.
- Re-capture of the same k within a frame: this is treated as a wrap (k <= last_idx) and closes the frame.
- Output timing: all outputs are registered, and pulse outputs are never high for more than 1 cycle.
- Simultaneous events: multi_err and frame_done cannot both come from the same slot. Timeout expiry in the same cycle as a capture is ignored; the capture wins and the counter resets.

Test Plan:
- Reset release, then a clean scan with 4 cycles per slot, positions 0..7 carrying bcd 8,7,6,5,4,3,2,1, for two full scans -> first frame_done after position 0 of scan 2; d1..d8 = 1,2,...,8; digit_valid = 8'hFF.
- Same scan with positions 5 and 6 driven 8'hFF (blanked) -> digit_valid = 8'b1001_1111; d2 and d3 hold their prior values; no multi_err.
- Slot with anodo_in = 8'b1111_1100 held 4 cycles -> exactly one multi_err pulse; no capture; the frame closes normally on the next wrap.
- One-cycle glitch (bcd changes for 1 cycle) with STABLE_CYC=2 -> glitch value not captured; the stable value is captured once.
- Capture position 3, then anodo_in = 8'hFF for 1100 cycles -> frame_done and timeout pulse together 1024 cycles after the capture; digit_valid = 8'b0000_1000; no further pulses.
- Assert reset mid-frame after 3 captures -> outputs clear immediately with no frame_done; the next full scan after release behaves as the first scenario.

Source files
------------

// File: rtl/bcd_scan_capture.sv
// Receive side of an 8-digit multiplexed BCD display scan: filters the sampled
// anode/BCD bus, captures one digit per stable slot and publishes whole frames.
module bcd_scan_capture #(
  parameter int unsigned STABLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] anodo_in,
  input  logic [3:0] bcd_in,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] d4,
  output logic [3:0] d5,
  output logic [3:0] d6,
  output logic [3:0] d7,
  output logic [3:0] d8,
  output logic [7:0] digit_valid,
  output logic       frame_done,
  output logic       multi_err,
  output logic       timeout
);

  logic [7:0]  an_r, an_p;
  logic [3:0]  bcd_r, bcd_p;
  logic [3:0]  stab_cnt;
  logic        held;
  logic [3:0]  shadow [8];
  logic [3:0]  dig    [8];
  logic [7:0]  mask;
  logic [2:0]  last_idx;
  logic        open;
  logic [15:0] tcnt;

  logic        changed, accept, blank, single, multi, capture, wrap;
  logic [7:0]  low;
  logic [2:0]  k;

  // an_p/bcd_p hold the value the stability count refers to; held blocks
  // repeated acceptance once the counter has saturated.
  always_comb begin
    low     = ~an_p;
    changed = ({an_r, bcd_r} != {an_p, bcd_p});
    accept  = !held && (stab_cnt == 4'(STABLE_CYC));
    blank   = (low == '0);
    single  = !blank && ((low & (low - 8'd1)) == '0);
    multi   = !blank && !single;
    capture = accept && single;
    k       = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (low[i]) k = 3'(i);
    end
    wrap    = open && (k <= last_idx);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_r        <= '1;
      an_p        <= '1;
      bcd_r       <= '0;
      bcd_p       <= '0;
      stab_cnt    <= '0;
      held        <= 1'b0;
      mask        <= '0;
      last_idx    <= '0;
      open        <= 1'b0;
      tcnt        <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      multi_err   <= 1'b0;
      timeout     <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        dig[i]    <= '0;
      end
    end else begin
      an_r  <= anodo_in;
      bcd_r <= bcd_in;
      an_p  <= an_r;
      bcd_p <= bcd_r;
      if (changed)
        stab_cnt <= 4'd1;
      else if (stab_cnt != 4'd15)
        stab_cnt <= stab_cnt + 4'd1;
      held <= !changed && (stab_cnt == 4'd15);

      frame_done <= 1'b0;
      timeout    <= 1'b0;
      multi_err  <= accept && multi;

      if (capture) begin
        // Publish uses the pre-capture shadow; the new digit seeds the next frame.
        if (wrap) begin
          for (int unsigned i = 0; i < 8; i++) begin
            if (mask[i]) dig[i] <= shadow[i];
          end
          digit_valid <= mask;
          frame_done  <= 1'b1;
          mask        <= 8'd1 << k;
        end else if (open) begin
          mask <= mask | (8'd1 << k);
        end else begin
          mask <= 8'd1 << k;
        end
        shadow[k] <= bcd_p;
        last_idx  <= k;
        open      <= 1'b1;
        tcnt      <= '0;
      end else if (open) begin
        if (tcnt == 16'(TIMEOUT_CYC - 1)) begin
          for (int unsigned i = 0; i < 8; i++) begin
            if (mask[i]) dig[i] <= shadow[i];
          end
          digit_valid <= mask;
          frame_done  <= 1'b1;
          timeout     <= 1'b1;
          open        <= 1'b0;
          mask        <= '0;
          tcnt        <= '0;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
      end
    end
  end

  assign d1 = dig[7];
  assign d2 = dig[6];
  assign d3 = dig[5];
  assign d4 = dig[4];
  assign d5 = dig[3];
  assign d6 = dig[2];
  assign d7 = dig[1];
  assign d8 = dig[0];

endmodule

// File: tb/tb_bcd_scan_capture.sv
// Bench for bcd_scan_capture: run-length/frame-list reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_bcd_scan_capture;

  localparam int STABLE  = 2;
  localparam int TOUT    = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] anodo_in;
  logic [3:0] bcd_in;
  logic [3:0] d1, d2, d3, d4, d5, d6, d7, d8;
  logic [7:0] digit_valid;
  logic       frame_done, multi_err, timeout;

  bcd_scan_capture #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .reset(reset), .anodo_in(anodo_in), .bcd_in(bcd_in),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
    .digit_valid(digit_valid), .frame_done(frame_done),
    .multi_err(multi_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fd_cnt = 0, to_cnt = 0, me_cnt = 0;
  int to_seen_cyc = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Samples reach the decision point two edges after they are taken; a slot is
  // accepted when its run of identical samples reaches exactly STABLE long.
  logic [11:0] q[$];
  logic [11:0] run_val;
  bit          run_valid;
  int          run_len;
  logic [3:0]  m_d[8];
  logic [3:0]  m_sh[8];
  logic [7:0]  m_valid, m_mask;
  bit          m_open;
  int          m_last, m_since;
  logic        m_fd, m_to, m_me;

  function automatic void publish();
    for (int i = 0; i < 8; i++) if (m_mask[i]) m_d[i] = m_sh[i];
    m_valid = m_mask;
    m_fd = 1'b1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q = {};
      q.push_back({8'hFF, 4'h0});
      run_valid = 0; run_len = 0;
      for (int i = 0; i < 8; i++) begin m_d[i] = '0; m_sh[i] = '0; end
      m_valid = '0; m_mask = '0; m_open = 0; m_last = 0; m_since = 0;
      m_fd = 0; m_to = 0; m_me = 0;
    end else begin
      logic [11:0] s;
      bit cap;
      int k, lows;
      m_fd = 0; m_to = 0; m_me = 0; cap = 0; k = 0;
      q.push_back({anodo_in, bcd_in});
      if (q.size() == 3) begin
        s = q.pop_front();
        if (run_valid && s == run_val) run_len++;
        else begin run_val = s; run_len = 1; run_valid = 1; end
        if (run_len == STABLE) begin
          lows = 0;
          for (int i = 0; i < 8; i++) if (!s[4+i]) begin lows++; k = i; end
          if (lows == 1) cap = 1;
          else if (lows > 1) m_me = 1;
        end
      end
      if (cap) begin
        if (m_open && k <= m_last) begin publish(); m_mask = '0; end
        if (!m_open) m_mask = '0;
        m_sh[k] = s[3:0];
        m_mask[k] = 1'b1;
        m_last = k; m_open = 1; m_since = 0;
      end else if (m_open) begin
        m_since++;
        if (m_since == TOUT) begin
          publish(); m_to = 1; m_open = 0; m_mask = '0;
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    check("digits", {d1, d2, d3, d4, d5, d6, d7, d8},
          {m_d[7], m_d[6], m_d[5], m_d[4], m_d[3], m_d[2], m_d[1], m_d[0]});
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("timeout", 32'(timeout), 32'(m_to));
    check("multi_err", 32'(multi_err), 32'(m_me));
    if (frame_done) fd_cnt++;
    if (timeout) begin to_cnt++; to_seen_cyc = cyc; end
    if (multi_err) me_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic slot(input logic [7:0] a, input logic [3:0] b, input int n);
    anodo_in = a;
    bcd_in   = b;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [7:0] sel(input int k);
    logic [7:0] one = 8'd1;
    return ~(one << k);
  endfunction

  task automatic scan_desc();
    for (int k = 0; k < 8; k++) slot(sel(k), 4'(8 - k), 4);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
  endtask

  initial begin
    int f0, t0, m0, start;
    reset = 1'b0; anodo_in = 8'hFF; bcd_in = 4'h0;
    repeat (2) begin @(posedge clk); #1; end
    check("reset_digits", {d1, d2, d3, d4, d5, d6, d7, d8}, 32'h0);
    check("reset_valid", 32'(digit_valid), 32'h0);
    reset = 1'b1;

    // Clean double scan
    f0 = fd_cnt;
    scan_desc(); scan_desc();
    slot(8'hFF, 4'h0, 8);
    check("scan1_digits", {d1, d2, d3, d4, d5, d6, d7, d8}, 32'h12345678);
    check("scan1_valid", 32'(digit_valid), 32'hFF);
    check("scan1_fd_count", 32'(fd_cnt - f0), 32'd1);

    // Positions 5 and 6 blanked, bcd = position
    m0 = me_cnt;
    for (int k = 0; k < 8; k++) slot((k == 5 || k == 6) ? 8'hFF : sel(k), 4'(k), 4);
    slot(sel(0), 4'h0, 4);
    slot(8'hFF, 4'h0, 8);
    check("blank_digits", {d1, d2, d3, d4, d5, d6, d7, d8}, 32'h72343210);
    check("blank_valid", 32'(digit_valid), 32'h9F);
    check("blank_no_multi", 32'(me_cnt - m0), 32'd0);

    // Multi-anode slot
    m0 = me_cnt; f0 = fd_cnt;
    slot(sel(1), 4'h9, 4);
    slot(sel(2), 4'h9, 4);
    slot(8'b1111_1100, 4'h6, 4);
    slot(sel(3), 4'h9, 4);
    slot(sel(0), 4'h1, 4);
    slot(8'hFF, 4'h0, 8);
    check("multi_count", 32'(me_cnt - m0), 32'd1);
    check("multi_fd_count", 32'(fd_cnt - f0), 32'd1);
    check("multi_valid", 32'(digit_valid), 32'h0F);

    // One-cycle glitch ahead of the stable value
    slot(sel(1), 4'h9, 1);
    slot(sel(1), 4'h5, 4);
    slot(sel(2), 4'h2, 4);
    slot(sel(0), 4'h1, 4);
    slot(8'hFF, 4'h0, 8);
    check("glitch_d7", 32'(d7), 32'h5);
    check("glitch_valid", 32'(digit_valid), 32'h07);

    // Timeout after a single capture
    do_reset();
    f0 = fd_cnt; t0 = to_cnt;
    start = cyc;
    slot(sel(3), 4'h5, 4);
    slot(8'hFF, 4'h0, 1100);
    check("to_fd_count", 32'(fd_cnt - f0), 32'd1);
    check("to_count", 32'(to_cnt - t0), 32'd1);
    check("to_latency", 32'(to_seen_cyc - start), 32'd1028);
    check("to_valid", 32'(digit_valid), 32'h08);
    check("to_d5", 32'(d5), 32'h5);

    // Reset mid-frame after three captures
    f0 = fd_cnt;
    for (int k = 0; k < 3; k++) slot(sel(k), 4'(8 - k), 4);
    reset = 1'b0;
    #1;
    check("midrst_digits", {d1, d2, d3, d4, d5, d6, d7, d8}, 32'h0);
    check("midrst_valid", 32'(digit_valid), 32'h0);
    check("midrst_fd", 32'(frame_done), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    scan_desc(); scan_desc();
    slot(8'hFF, 4'h0, 8);
    check("midrst_fd_count", 32'(fd_cnt - f0), 32'd1);
    check("rescan_digits", {d1, d2, d3, d4, d5, d6, d7, d8}, 32'h12345678);
    check("rescan_valid", 32'(digit_valid), 32'hFF);

    // Randomised slots against the model
    for (int n = 0; n < 400; n++) begin
      int r, a, b;
      logic [7:0] one;
      one = 8'd1;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        slot(8'hFF, 4'($urandom_range(0, 15)), $urandom_range(1, 6));
      end else if (r == 1) begin
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        slot(~((one << a) | (one << b)), 4'($urandom_range(0, 15)), $urandom_range(1, 6));
      end else begin
        slot(sel($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom_range(1, 6));
      end
    end
    slot(8'hFF, 4'h0, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
